// File: rtl/key_debounce.sv
// key_debounce
//   Debounces NUM_KEYS active-low pushbuttons and generates press, release
//   and auto-repeat pulses for each channel.
//
//   Ports
//     CLOCK_50    : single clock; every register uses its rising edge
//     RESET_N     : synchronous active-low reset
//     KEY         : raw asynchronous buttons, 0 = pressed
//     repeat_en   : enables auto-repeat on all channels
//     key_down    : debounced level, 1 = pressed
//     key_press   : 1-cycle pulse on a debounced press
//     key_release : 1-cycle pulse on a debounced release
//     key_repeat  : 1-cycle auto-repeat pulse
//     any_press   : OR of all key_press bits, same cycle
//
//   Repeat FSM (one per channel)
//     state     | meaning
//     ST_IDLE   | key released, or repeat disabled, or held since before enable
//     ST_DELAY  | key held, counting toward the first repeat pulse
//     ST_REPEAT | key held, emitting a pulse every REPEAT_PERIOD clocks
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_press
);

  localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  logic [NUM_KEYS-1:0]         s1_q, s1_d;
  logic [NUM_KEYS-1:0]         s2_q, s2_d;
  logic [NUM_KEYS-1:0]         stable_q, stable_d;
  logic [NUM_KEYS-1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [NUM_KEYS-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
  rpt_state_e                  state_q [NUM_KEYS];
  rpt_state_e                  state_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]         press_q, press_d;
  logic [NUM_KEYS-1:0]         release_q, release_d;
  logic [NUM_KEYS-1:0]         repeat_q, repeat_d;
  logic                        any_press_q, any_press_d;

  always_comb begin
    s1_d        = KEY;
    s2_d        = s1_q;
    stable_d    = stable_q;
    db_cnt_d    = db_cnt_q;
    rpt_cnt_d   = rpt_cnt_q;
    press_d     = '0;
    release_d   = '0;
    repeat_d    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
    end

    for (int i = 0; i < NUM_KEYS; i++) begin
      // Any sample matching the stable level restarts the interval.
      if (s2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end

      // Pulses are computed from the next stable value so they line up
      // with the key_down edge.
      press_d[i]   = stable_q[i] & ~stable_d[i];
      release_d[i] = ~stable_q[i] & stable_d[i];

      if (release_d[i] || !repeat_en) begin
        state_d[i]   = ST_IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            // Only a fresh press arms repeat; a key held before enable stays idle.
            if (press_d[i]) begin
              state_d[i]   = ST_DELAY;
              rpt_cnt_d[i] = '0;
            end
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == DELAY_LAST) begin
              repeat_d[i]  = 1'b1;
              state_d[i]   = ST_REPEAT;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == PERIOD_LAST) begin
              repeat_d[i]  = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end

    any_press_d = |press_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      s1_q        <= '1;
      s2_q        <= '1;
      stable_q    <= '1;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign key_down    = ~stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign any_press   = any_press_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
//   REPEAT_PERIOD=5. Inputs change just after a falling edge; outputs are
//   sampled on falling edges. "Edge e" is the e-th rising edge after an
//   input change.
module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       repeat_en;
  logic [3:0] key_down;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic       any_press;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .KEY        (key),
    .repeat_en  (repeat_en),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key = 4'hF;
    repeat_en = 1'b0;
    step();
    step();
    n_cmp++;
    if ({key_down, key_press, key_release, key_repeat, any_press} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0",
               {key_down, key_press, key_release, key_repeat, any_press});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      n_cmp++;
      if ({key_down, key_press, key_release, key_repeat, any_press} !== 17'h0) begin
        n_err++;
        $display("FAIL idle_after_reset e=%0d got=%h exp=0", e,
                 {key_down, key_press, key_release, key_repeat, any_press});
      end
    end
  endtask

  task automatic test_press_release();
    key[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_cmp++;
      if (key_press[0] !== (e == 10) || any_press !== (e == 10) || key_down[0] !== (e >= 10)) begin
        n_err++;
        $display("FAIL press0 e=%0d got press=%b any=%b down=%b exp press=%b any=%b down=%b",
                 e, key_press[0], any_press, key_down[0], e == 10, e == 10, e >= 10);
      end
    end
    key[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_cmp++;
      if (key_release[0] !== (e == 10) || key_down[0] !== (e < 10) || key_press[0] !== 1'b0) begin
        n_err++;
        $display("FAIL release0 e=%0d got rel=%b down=%b press=%b exp rel=%b down=%b press=0",
                 e, key_release[0], key_down[0], key_press[0], e == 10, e < 10);
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) key[1] = ~key[1];
      step();
      n_cmp++;
      if (key_down[1] !== 1'b0 || key_press[1] !== 1'b0 || key_release[1] !== 1'b0) begin
        n_err++;
        $display("FAIL bounce1 c=%0d got down=%b press=%b rel=%b exp 0 0 0",
                 c, key_down[1], key_press[1], key_release[1]);
      end
    end
    key[1] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      n_cmp++;
      if (key_down[1] !== 1'b0 || key_press[1] !== 1'b0 || key_release[1] !== 1'b0) begin
        n_err++;
        $display("FAIL bounce1_settle c=%0d got down=%b press=%b rel=%b exp 0 0 0",
                 c, key_down[1], key_press[1], key_release[1]);
      end
    end
  endtask

  task automatic test_repeat();
    logic exp;
    repeat_en = 1'b1;
    key[2] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++;
      if (key_press[2] !== (e == 10) || key_repeat[2] !== 1'b0) begin
        n_err++;
        $display("FAIL press2 e=%0d got press=%b rpt=%b exp press=%b rpt=0",
                 e, key_press[2], key_repeat[2], e == 10);
      end
    end
    for (int k = 1; k <= 59; k++) begin
      step();
      exp = (k >= 20) && ((k - 20) % 5 == 0);
      n_cmp++;
      if (key_repeat[2] !== exp || key_repeat[1:0] !== 2'b00 || key_repeat[3] !== 1'b0) begin
        n_err++;
        $display("FAIL repeat2 k=%0d got=%b exp_bit2=%b", k, key_repeat, exp);
      end
    end
  endtask

  task automatic test_release_after_repeat();
    key[2] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++;
      if (key_release[2] !== (e == 10)) begin
        n_err++;
        $display("FAIL release2 e=%0d got=%b exp=%b", e, key_release[2], e == 10);
      end
    end
    for (int e = 1; e <= 30; e++) begin
      step();
      n_cmp++;
      if (key_repeat !== 4'b0000 || key_release[2] !== 1'b0) begin
        n_err++;
        $display("FAIL no_repeat_after_release e=%0d got rpt=%b rel2=%b exp 0000 0",
                 e, key_repeat, key_release[2]);
      end
    end
  endtask

  task automatic test_late_enable();
    repeat_en = 1'b0;
    key[3] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_cmp++;
      if (key_press[3] !== (e == 10)) begin
        n_err++;
        $display("FAIL press3_noen e=%0d got=%b exp=%b", e, key_press[3], e == 10);
      end
    end
    repeat_en = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      n_cmp++;
      if (key_repeat !== 4'b0000) begin
        n_err++;
        $display("FAIL late_enable e=%0d got=%b exp=0000", e, key_repeat);
      end
    end
    key[3] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_cmp++;
      if (key_release[3] !== (e == 10)) begin
        n_err++;
        $display("FAIL release3 e=%0d got=%b exp=%b", e, key_release[3], e == 10);
      end
    end
  endtask

  task automatic test_back_to_back();
    key[0] = 1'b0;
    key[3] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      step();
      n_cmp++;
      if (key_press !== ((e == 10) ? 4'b1001 : 4'b0000) || any_press !== (e == 10)) begin
        n_err++;
        $display("FAIL simul_press e=%0d got press=%b any=%b exp press=%b any=%b",
                 e, key_press, any_press, (e == 10) ? 4'b1001 : 4'b0000, e == 10);
      end
    end
    key[0] = 1'b1;
    key[3] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_cmp++;
      if (key_release !== ((e == 10) ? 4'b1001 : 4'b0000) || key_repeat !== 4'b0000) begin
        n_err++;
        $display("FAIL simul_release e=%0d got rel=%b rpt=%b exp rel=%b rpt=0000",
                 e, key_release, key_repeat, (e == 10) ? 4'b1001 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    repeat_en = 1'b1;
    key[1] = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    n_cmp++;
    if (key_press[1] !== 1'b1) begin
      n_err++;
      $display("FAIL press1_pre_reset got=%b exp=1", key_press[1]);
    end
    for (int k = 1; k <= 22; k++) step();
    n_cmp++;
    if (key_down[1] !== 1'b1) begin
      n_err++;
      $display("FAIL down1_pre_reset got=%b exp=1", key_down[1]);
    end
    rst_n = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_cmp++;
      if ({key_down, key_press, key_release, key_repeat, any_press} !== 17'h0) begin
        n_err++;
        $display("FAIL in_reset e=%0d got=%h exp=0", e,
                 {key_down, key_press, key_release, key_repeat, any_press});
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_cmp++;
      if (key_press[1] !== (e == 10) || key_repeat !== 4'b0000 || key_release !== 4'b0000) begin
        n_err++;
        $display("FAIL press1_post_reset e=%0d got press=%b rpt=%b rel=%b exp press=%b",
                 e, key_press[1], key_repeat, key_release, e == 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_repeat();
    test_release_after_repeat();
    test_late_enable();
    test_back_to_back();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter NUM_KEYS, default 4, giving the number of independent pushbutton channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-input interval in clocks (20 ms at 50 MHz); legal range ≥2.
REQ-003 The module SHALL have parameter REPEAT_DELAY, default 25000000, giving the clocks from debounced press to the first repeat pulse; legal range ≥2.
REQ-004 The module SHALL have parameter REPEAT_PERIOD, default 5000000, giving the clocks between later repeat pulses; legal range ≥2.
REQ-005 The module SHALL have port CLOCK_50, input, 1 bit, the single clock; every register SHALL be clocked on its rising edge.
REQ-006 The module SHALL have port RESET_N, input, 1 bit: synchronous, active-low reset, sampled on CLOCK_50.
REQ-007 The module SHALL have port KEY, input, NUM_KEYS bits: raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-008 The module SHALL have port repeat_en, input, 1 bit, which enables auto-repeat on all channels when 1.
REQ-009 The module SHALL have port key_down, output, NUM_KEYS bits: debounced level, active-high (1 = pressed); it drives pushbuttons_export.
REQ-010 The module SHALL have port key_press, output, NUM_KEYS bits: a 1-cycle pulse on each debounced press.
REQ-011 The module SHALL have port key_release, output, NUM_KEYS bits: a 1-cycle pulse on each debounced release.
REQ-012 The module SHALL have port key_repeat, output, NUM_KEYS bits: a 1-cycle auto-repeat pulse.
REQ-013 The module SHALL have port any_press, output, 1 bit, equal to the registered OR of all key_press bits in the same cycle.

Function
REQ-014 Each channel SHALL pass KEY[i] through a 2-flop synchronizer (s1, s2) before any other logic uses it.
REQ-015 Each channel SHALL hold a stable register and a debounce counter ceil(log2(DEBOUNCE_CYCLES)) bits wide.
REQ-016 When s2 == stable, the debounce counter SHALL load 0 on the next edge, so any bounce shorter than DEBOUNCE_CYCLES restarts the count.
REQ-017 When s2 != stable and counter < DEBOUNCE_CYCLES-1, the debounce counter SHALL increment by 1.
REQ-018 When s2 != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL load s2 and the counter SHALL load 0.
REQ-019 Latency: a raw level held constant SHALL change key_down exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-020 key_down[i] SHALL equal ~stable[i].
REQ-021 key_press[i] and key_release[i] SHALL be registered and SHALL assert in the same cycle key_down[i] rises or falls respectively, for exactly one cycle.
REQ-022 Each channel SHALL run a repeat FSM with states IDLE, DELAY and REPEAT, and a repeat counter ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD))) bits wide.
REQ-023 In IDLE, on a debounced press with repeat_en=1, the FSM SHALL go to DELAY and the repeat counter SHALL load 0.
REQ-024 In DELAY, the repeat counter SHALL increment; when it reaches REPEAT_DELAY-1, key_repeat SHALL pulse, the FSM SHALL go to REPEAT and the counter SHALL load 0.
REQ-025 In REPEAT, the repeat counter SHALL increment; when it reaches REPEAT_PERIOD-1, key_repeat SHALL pulse and the counter SHALL load 0.
REQ-026 A debounced release, or repeat_en=0, SHALL force the FSM to IDLE and the counter to 0 on the next edge, and key_repeat SHALL NOT assert in that cycle.
REQ-027 If repeat_en rises while a key is already held, that key SHALL NOT start repeating until its next press.
REQ-028 Channels SHALL be fully independent, and simultaneous pulses on several channels in one cycle SHALL be legal.
REQ-029 The debounce and repeat counters SHALL never wrap, and no pulse output SHALL assert for two consecutive cycles.

Reset
REQ-030 While RESET_N=0 at an edge, s1, s2 and stable SHALL load all-ones (released), all counters SHALL load 0, and all FSMs SHALL load IDLE.
REQ-031 While RESET_N=0 at an edge, key_down, key_press, key_release, key_repeat and any_press SHALL load 0.
REQ-032 A key held through reset deassertion SHALL be reported as a fresh press: key_press pulses DEBOUNCE_CYCLES+2 edges after the first edge with RESET_N=1.
REQ-033 Reset asserted mid-debounce or mid-repeat SHALL abort the operation without emitting any pulse.

Verification (bench parameters DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-034 Scenario: KEY[0] 1→0 held → key_down[0] rises and key_press[0] pulses once at edge 10; any_press pulses in that same cycle.
REQ-035 Scenario: KEY[1] toggles every 5 clocks for 60 clocks, then stays 1 → key_down[1], key_press[1] and key_release[1] stay 0 throughout.
REQ-036 Scenario: repeat_en=1, KEY[2] held for 60 clocks after its press pulse → key_repeat[2] pulses at press+20, +25, +30, +35, +40, +45, +50, +55.
REQ-037 Scenario: the key from REQ-036 is released → key_release[2] pulses 10 edges after the release and no key_repeat follows.
REQ-038 Scenario: KEY[0] and KEY[3] fall on the same edge → key_press[0] and key_press[3] pulse in the same cycle.
REQ-039 Scenario: KEY[1] is held, then RESET_N=0 for 3 cycles mid-repeat → all outputs are 0 during reset, and key_press[1] pulses 10 edges after reset release.
